fetch_stage: RTL and testbench

- IF stage of the 5-stage RV32I pipeline.
- Owns the PC and the instruction-memory request handshake, and drives the IF/ID pipeline register.
- Consumes HD_PC_write / HD_IF_ID_write from the hazard detector for load-use stalls, and EX branch/jump redirects.
- Feeds ID, which feeds the hazard detector its rs1/rs2.

---
 rtl/fetch_stage_pkg.sv | 12 +
 rtl/fetch_stage_if_id_reg.sv | 36 +++
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds pc/instr/valid, loads on write enable,
// and inserts a NOP bubble when bubble is asserted.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             bubble,
    input  logic [width-1:0] pc_d,
    input  logic [31:0]      instr_d,
    output logic [width-1:0] pc_q,
    output logic [31:0]      instr_q,
    output logic             valid_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (we) begin
            pc_q <= pc_d;
            if (bubble) begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end else begin
                instr_q <= instr_d;
                valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, instruction-memory handshake and IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int               width    = 32,
    parameter logic [width-1:0] RESET_PC = 'h4000_0060
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             HD_PC_write_i,
    input  logic             HD_IF_ID_write_i,
    input  logic             EX_br_en_i,
    input  logic [width-1:0] EX_br_target_i,
    output logic [width-1:0] imem_address_o,
    output logic             imem_read_o,
    input  logic [31:0]      imem_rdata_i,
    input  logic             imem_resp_i,
    output logic [width-1:0] IF_ID_pc_o,
    output logic [31:0]      IF_ID_instr_o,
    output logic             IF_ID_valid_o,
    output logic             IF_stall_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetch_cnt_o,
    output logic [31:0]      perf_stall_cnt_o
`endif
);

    localparam logic [width-1:0] PC_STEP    = width'(4);
    localparam logic [width-1:0] ALIGN_MASK = ~width'(3);

    fetch_state_t     state_q, state_d;
    logic [width-1:0] pc_q, pc_d;
    logic [width-1:0] tgt_q, tgt_d;
    logic [31:0]      hold_q, hold_d;
    logic [width-1:0] target;
    logic             avail;
    logic             accept;
    logic [31:0]      instr_src;

    assign target = EX_br_target_i & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            hold_q  <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            hold_q  <= hold_d;
        end
    end

    // A redirect with the request still outstanding must keep the old address
    // until its response is swallowed, hence the DISCARD detour.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        hold_d  = hold_q;
        case (state_q)
            FETCH: begin
                if (EX_br_en_i) begin
                    if (imem_resp_i) begin
                        pc_d = target;
                    end else begin
                        tgt_d   = target;
                        state_d = DISCARD;
                    end
                end else if (accept) begin
                    pc_d = pc_q + PC_STEP;
                end else if (imem_resp_i) begin
                    hold_d  = imem_rdata_i;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (EX_br_en_i) begin
                    pc_d    = target;
                    hold_d  = NOP_INSTR;
                    state_d = FETCH;
                end else if (accept) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                if (imem_resp_i) begin
                    pc_d    = EX_br_en_i ? target : tgt_q;
                    state_d = FETCH;
                end else if (EX_br_en_i) begin
                    tgt_d = target;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        imem_address_o = pc_q;
        imem_read_o    = rst & (state_q != HOLD);
        avail          = ((state_q == FETCH) & imem_resp_i) | (state_q == HOLD);
        accept         = avail & HD_IF_ID_write_i & HD_PC_write_i & ~EX_br_en_i;
        instr_src      = (state_q == HOLD) ? hold_q : imem_rdata_i;
        IF_stall_o     = ~avail;
    end

    if_id_reg #(.width(width)) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .we      (HD_IF_ID_write_i | EX_br_en_i),
        .bubble  (~accept),
        .pc_d    (pc_q),
        .instr_d (instr_src),
        .pc_q    (IF_ID_pc_o),
        .instr_q (IF_ID_instr_o),
        .valid_q (IF_ID_valid_o)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (accept && perf_fetch_cnt_o != '1)
                perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
            if (IF_stall_o && perf_stall_cnt_o != '1)
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed steps plus randomized traffic
// checked against a transaction-level fetch model with a latency-driven memory.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h4000_0060;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        HD_PC_write_i;
    logic        HD_IF_ID_write_i;
    logic        EX_br_en_i;
    logic [31:0] EX_br_target_i;
    logic [31:0] imem_address_o;
    logic        imem_read_o;
    logic [31:0] imem_rdata_i;
    logic        imem_resp_i;
    logic [31:0] IF_ID_pc_o;
    logic [31:0] IF_ID_instr_o;
    logic        IF_ID_valid_o;
    logic        IF_stall_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_stall_cnt_o;
`endif

    fetch_stage #(.width(32), .RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .HD_PC_write_i    (HD_PC_write_i),
        .HD_IF_ID_write_i (HD_IF_ID_write_i),
        .EX_br_en_i       (EX_br_en_i),
        .EX_br_target_i   (EX_br_target_i),
        .imem_address_o   (imem_address_o),
        .imem_read_o      (imem_read_o),
        .imem_rdata_i     (imem_rdata_i),
        .imem_resp_i      (imem_resp_i),
        .IF_ID_pc_o       (IF_ID_pc_o),
        .IF_ID_instr_o    (IF_ID_instr_o),
        .IF_ID_valid_o    (IF_ID_valid_o),
        .IF_stall_o       (IF_stall_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: next address to fetch, whether a fetched word is parked,
    // whether the in-flight response must be dropped, and the expected IF/ID.
    logic [31:0] m_addr, m_tgt;
    bit          m_held, m_drop;
    int unsigned m_wait, m_lat;
    int          lat_cfg;
    logic [31:0] e_pc, e_instr;
    bit          e_valid;
    int unsigned e_fetch, e_stall;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h00A0_0093;
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_lat(input int l);
        lat_cfg = l;
        m_lat   = (l < 0) ? $urandom_range(3, 0) : l;
    endtask

    task automatic model_reset();
        m_addr  = RST_PC;
        m_tgt   = '0;
        m_held  = 0;
        m_drop  = 0;
        m_wait  = 0;
        e_pc    = '0;
        e_instr = NOP;
        e_valid = 0;
        e_fetch = 0;
        e_stall = 0;
    endtask

    // One clock: check registered state, drive inputs, check combinational outputs,
    // clock, then advance the model. Entered and left just after a falling edge.
    task automatic cycle(input bit hdif, input bit hdpc, input bit br, input logic [31:0] tgt);
        bit          reading, resp, avail, accept;
        logic [31:0] t;
        chk("ifid_valid", {31'b0, IF_ID_valid_o}, {31'b0, e_valid});
        if (e_valid) begin
            chk("ifid_pc", IF_ID_pc_o, e_pc);
            chk("ifid_instr", IF_ID_instr_o, e_instr);
        end
        reading          = !m_held;
        resp             = reading && (m_wait >= m_lat);
        HD_IF_ID_write_i = hdif;
        HD_PC_write_i    = hdpc;
        EX_br_en_i       = br;
        EX_br_target_i   = tgt;
        imem_resp_i      = resp;
        imem_rdata_i     = resp ? mem_word(m_addr) : $urandom;
        #1;
        avail  = (resp && !m_drop) || m_held;
        accept = avail && hdif && hdpc && !br;
        chk("imem_read", {31'b0, imem_read_o}, {31'b0, reading});
        chk("imem_addr", imem_address_o, m_addr);
        chk("if_stall", {31'b0, IF_stall_o}, {31'b0, !avail});
        t = tgt & 32'hFFFF_FFFC;
        @(posedge clk);
        if (accept) e_fetch++;
        if (!avail) e_stall++;
        if (br) begin
            e_valid = 0;
            m_held  = 0;
            if (resp || !reading) begin
                m_addr = t;
                m_drop = 0;
            end else begin
                m_drop = 1;
                m_tgt  = t;
            end
        end else begin
            if (accept) begin
                e_pc    = m_addr;
                e_instr = mem_word(m_addr);
                e_valid = 1;
            end else if (hdif) begin
                e_valid = 0;
            end
            if (m_drop && resp) begin
                m_addr = m_tgt;
                m_drop = 0;
            end else if (accept) begin
                m_addr = m_addr + 32'd4;
                m_held = 0;
            end else if (resp) begin
                m_held = 1;
            end
        end
        if (resp) begin
            m_wait = 0;
            m_lat  = (lat_cfg < 0) ? $urandom_range(3, 0) : lat_cfg;
        end else if (reading) begin
            m_wait++;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_read"}, {31'b0, imem_read_o}, 32'd0);
        chk({tag, "_addr"}, imem_address_o, RST_PC);
        chk({tag, "_valid"}, {31'b0, IF_ID_valid_o}, 32'd0);
        chk({tag, "_pc"}, IF_ID_pc_o, 32'd0);
        chk({tag, "_instr"}, IF_ID_instr_o, NOP);
    endtask

    initial begin
        rst              = 1'b0;
        HD_PC_write_i    = 1'b1;
        HD_IF_ID_write_i = 1'b1;
        EX_br_en_i       = 1'b0;
        EX_br_target_i   = '0;
        imem_rdata_i     = '0;
        imem_resp_i      = 1'b0;
        model_reset();
        set_lat(0);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Zero-wait memory straight out of reset
        rst = 1'b1;
        repeat (3) cycle(1, 1, 0, '0);

        // Three-cycle latency
        set_lat(3);
        repeat (9) cycle(1, 1, 0, '0);

        // Response during a two-cycle stall parks the word in HOLD
        set_lat(0);
        repeat (2) cycle(0, 0, 0, '0);
        repeat (3) cycle(1, 1, 0, '0);

        // Redirect with a request outstanding, then the stale response is dropped
        set_lat(3);
        cycle(1, 1, 0, '0);
        cycle(1, 1, 1, 32'h4000_0103);
        repeat (6) cycle(1, 1, 0, '0);

        // Redirect coincident with a response and a stall
        set_lat(0);
        cycle(0, 0, 1, 32'h4000_0203);
        repeat (2) cycle(1, 1, 0, '0);

        // Disagreeing hazard enables stall the fetch
        cycle(1, 0, 0, '0);
        cycle(0, 1, 0, '0);
        cycle(1, 1, 0, '0);

        // Redirect while holding a word
        cycle(0, 0, 0, '0);
        cycle(1, 1, 1, 32'h4000_0300);
        repeat (2) cycle(1, 1, 0, '0);

        // Back-to-back redirects in DISCARD: newest target wins
        set_lat(3);
        cycle(1, 1, 0, '0);
        cycle(1, 1, 1, 32'h4000_0400);
        cycle(1, 1, 1, 32'h4000_0500);
        repeat (8) cycle(1, 1, 0, '0);

        // PC wraps from the top of the address space
        set_lat(0);
        cycle(1, 1, 1, 32'hFFFF_FFFE);
        repeat (3) cycle(1, 1, 0, '0);

        // Randomized traffic
        set_lat(-1);
        for (int i = 0; i < 400; i++) begin
            bit br;
            br = ($urandom_range(9, 0) == 0);
            cycle(($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0), br, $urandom);
        end

        // Settle to a fresh request, enter DISCARD, then reset asynchronously
        set_lat(3);
        cycle(1, 1, 1, 32'h2000_0000);
        for (int i = 0; i < 20 && (m_held || m_drop || m_wait != 0); i++)
            cycle(1, 1, 0, '0);
        cycle(1, 1, 0, '0);
        cycle(1, 1, 1, 32'h1234_5678);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt_o, e_fetch);
        chk("perf_stall", perf_stall_cnt_o, e_stall);
`endif
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
`ifdef FETCH_PERF_EN
        chk("perf_fetch_rst", perf_fetch_cnt_o, 32'd0);
        chk("perf_stall_rst", perf_stall_cnt_o, 32'd0);
`endif
        @(negedge clk);
        model_reset();
        set_lat(1);
        imem_resp_i = 1'b0;
        rst = 1'b1;
        repeat (4) cycle(1, 1, 0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
